// File: rtl/dffram_dp.sv
// -----------------------------------------------------------------------------
// dffram_dp
//   1R1W byte-maskable flop RAM with a 1-cycle registered read port,
//   write-first forwarding on same-address collisions, an optional
//   post-reset clear sweep and optional per-byte even parity.
//
//   Optional feature macro: DFFRAM_PARITY_EN
//     defined   -> one extra parity bit per byte lane, par_err_o live,
//                  err_inj_i corrupts byte-0 parity on writes to lane 0
//     undefined -> array is DATA_W bits wide, par_err_o tied to 0,
//                  err_inj_i ignored
//
// Parameters
//   DATA_W          word width (multiple of 8), NB = DATA_W/8 byte lanes
//   ADDR_W          address width, DEPTH = 2**ADDR_W words
//   CLEAR_ON_RESET  1: sweep zeros into every word after reset
//
// Ports
//   clk_i        clock, all state on rising edge
//   rst_ni       asynchronous active-low reset, synchronous release
//   rd_en_i      read request
//   rd_addr_i    read address
//   rd_data_o    registered read data (holds when no read)
//   rd_valid_o   rd_data_o updated this cycle
//   wr_en_i      write request
//   wr_addr_i    write address
//   wr_be_i      per-byte write enable, bit i -> bits [8i+7:8i]
//   wr_data_i    write data
//   err_inj_i    with a lane-0 write: store inverted parity for byte 0
//   busy_o       clear sweep in progress, requests ignored
//   par_err_o    parity mismatch on the returned word
//   dbg_state_o  FSM state (0 = INIT, 1 = READY)
//
// Handshake: there is no back-pressure. A request is taken on any rising
// edge where its enable is high and busy_o is low; while busy_o is high
// enables are dropped without effect. rd_valid_o is a one-cycle strobe.
// -----------------------------------------------------------------------------
module dffram_dp #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   rd_en_i,
  input  logic [ADDR_W-1:0]      rd_addr_i,
  output logic [DATA_W-1:0]      rd_data_o,
  output logic                   rd_valid_o,
  input  logic                   wr_en_i,
  input  logic [ADDR_W-1:0]      wr_addr_i,
  input  logic [DATA_W/8-1:0]    wr_be_i,
  input  logic [DATA_W-1:0]      wr_data_i,
  input  logic                   err_inj_i,
  output logic                   busy_o,
  output logic                   par_err_o,
  output logic                   dbg_state_o
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Clear-sweep FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if (CLEAR_ON_RESET) state_q <= ST_INIT;
      else                state_q <= ST_READY;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        // The last word is written in this cycle; the sweep never wraps.
        if (cnt_q == LAST_ADDR) state_d = ST_READY;
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  logic ready;
  assign ready       = (state_q == ST_READY);
  assign busy_o      = (state_q == ST_INIT);
  assign dbg_state_o = state_q;

  logic rd_fire, wr_fire, collide;
  assign rd_fire = rd_en_i & ready;
  assign wr_fire = wr_en_i & ready;
  assign collide = rd_fire & wr_fire & (rd_addr_i == wr_addr_i);

  // ---------------------------------------------------------------------------
  // Write port mux: the sweep owns the array while in INIT
  // ---------------------------------------------------------------------------
  logic [NB-1:0]     lane_we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    lane_we = '0;
    waddr   = wr_addr_i;
    wdata   = wr_data_i;
    if (state_q == ST_INIT) begin
      lane_we = '1;
      waddr   = cnt_q;
      wdata   = '0;
    end else if (wr_fire) begin
      lane_we = wr_be_i;
    end
  end

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; only the sweep initialises it.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NB; i++) begin
      if (lane_we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // ---------------------------------------------------------------------------
  // Read port with write-first forwarding per lane
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rd_word;
  logic [NB-1:0]     fwd_lane;

  always_comb begin
    rd_word  = mem[rd_addr_i];
    fwd_lane = '0;
    for (int i = 0; i < NB; i++) begin
      if (collide && wr_be_i[i]) begin
        rd_word[8*i +: 8] = wr_data_i[8*i +: 8];
        fwd_lane[i]       = 1'b1;
      end
    end
  end

  logic perr;

`ifdef DFFRAM_PARITY_EN
  logic [NB-1:0] wpar;
  logic [NB-1:0] par_mem [DEPTH];

  // Even parity per byte; the sweep writes zero data so parity 0 falls out.
  always_comb begin
    wpar = '0;
    for (int i = 0; i < NB; i++) begin
      wpar[i] = ^wdata[8*i +: 8];
    end
    if (wr_fire && wr_be_i[0] && err_inj_i) wpar[0] = ~wpar[0];
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NB; i++) begin
      if (lane_we[i]) par_mem[waddr][i] <= wpar[i];
    end
  end

  // Forwarded lanes come straight from wr_data_i and are never flagged.
  always_comb begin
    perr = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (!fwd_lane[i] &&
          (par_mem[rd_addr_i][i] != (^mem[rd_addr_i][8*i +: 8]))) begin
        perr = 1'b1;
      end
    end
  end
`else
  logic unused_par_inputs;
  assign unused_par_inputs = err_inj_i ^ (|fwd_lane);
  assign perr = 1'b0;
`endif

  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              par_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      if (rd_fire) rd_data_q <= rd_word;
      rd_valid_q <= rd_fire;
      par_err_q  <= rd_fire & perr;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign par_err_o  = par_err_q;

endmodule

// File: tb/tb_dffram_dp.sv
// -----------------------------------------------------------------------------
// tb_dffram_dp
//   Directed bench for dffram_dp with default parameters (32-bit words,
//   4096 entries, clear sweep enabled). Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_dffram_dp;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        rd_en_i;
  logic [11:0] rd_addr_i;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic        wr_en_i;
  logic [11:0] wr_addr_i;
  logic [3:0]  wr_be_i;
  logic [31:0] wr_data_i;
  logic        err_inj_i;
  logic        busy_o;
  logic        par_err_o;
  logic        dbg_state_o;

  int n_pass  = 0;
  int n_total = 0;

  // ---------------------------------------------------------------------------
  // Clock / reset / watchdog
  // ---------------------------------------------------------------------------
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  dffram_dp dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rd_en_i     (rd_en_i),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_be_i     (wr_be_i),
    .wr_data_i   (wr_data_i),
    .err_inj_i   (err_inj_i),
    .busy_o      (busy_o),
    .par_err_o   (par_err_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en_i   = 1'b0;
    wr_en_i   = 1'b0;
    err_inj_i = 1'b0;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic inj);
    wr_en_i   = 1'b1;
    wr_addr_i = a;
    wr_data_i = d;
    wr_be_i   = be;
    err_inj_i = inj;
    step();
    idle_inputs();
  endtask

  // Read, check data/valid/parity, then check the strobe drops and data holds.
  task automatic do_read(input string tag, input logic [11:0] a,
                         input logic [31:0] exp, input logic exp_perr);
    rd_en_i   = 1'b1;
    rd_addr_i = a;
    step();
    idle_inputs();
    check({tag, "_data"},  rd_data_o,  exp);
    check({tag, "_valid"}, {31'd0, rd_valid_o}, 32'd1);
    check({tag, "_perr"},  {31'd0, par_err_o},  {31'd0, exp_perr});
    step();
    check({tag, "_valid_drop"}, {31'd0, rd_valid_o}, 32'd0);
    check({tag, "_hold"},  rd_data_o,  exp);
  endtask

  // Counts cycles with busy_o high, starting right after reset release.
  // One-cycle read+write attempt injected at cycle inj_at (addr inj_addr).
  task automatic count_busy(input int inj_at, input logic [11:0] inj_addr,
                            output int n, output logic saw_valid);
    n = 0;
    saw_valid = 1'b0;
    while (busy_o && n < 5000) begin
      n++;
      if (n == inj_at) begin
        wr_en_i   = 1'b1;
        wr_addr_i = inj_addr;
        wr_data_i = 32'hFFFF_FFFF;
        wr_be_i   = 4'hF;
        rd_en_i   = 1'b1;
        rd_addr_i = inj_addr;
      end
      step();
      idle_inputs();
      if (rd_valid_o) saw_valid = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int   n_busy;
  logic saw_v;
  logic exp_par;

  initial begin
    rst_ni    = 1'b0;
    rd_addr_i = '0;
    wr_addr_i = '0;
    wr_data_i = '0;
    wr_be_i   = '0;
    idle_inputs();
    step();
    step();

    // Reset state
    check("rst_rd_data",  rd_data_o, 32'h0);
    check("rst_rd_valid", {31'd0, rd_valid_o}, 32'd0);
    check("rst_par_err",  {31'd0, par_err_o},  32'd0);
    check("rst_busy",     {31'd0, busy_o},     32'd1);
    check("rst_state",    {31'd0, dbg_state_o}, 32'd0);

    // 1: sweep length, then a swept word reads zero
    rst_ni = 1'b1;
    count_busy(0, 12'd0, n_busy, saw_v);
    check("sweep_cycles", n_busy, 32'd4096);
    check("sweep_no_valid", {31'd0, saw_v}, 32'd0);
    check("ready_state", {31'd0, dbg_state_o}, 32'd1);
    do_read("t1_rd_abc", 12'hABC, 32'h0000_0000, 1'b0);

    // 2: full-word write then read
    do_write(12'd5, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    do_read("t2_rd5", 12'd5, 32'hDEAD_BEEF, 1'b0);

    // 3: partial write lanes 0 and 2
    do_write(12'd5, 32'h1122_3344, 4'b0101, 1'b0);
    do_read("t3_rd5", 12'd5, 32'hDE22_BE44, 1'b0);

    // wr_be_i = 0 is a no-op
    do_write(12'd5, 32'h0000_0000, 4'b0000, 1'b0);
    do_read("be0_rd5", 12'd5, 32'hDE22_BE44, 1'b0);

    // 4: same-address collision with forwarding on lanes 0,1
    do_write(12'd7, 32'hAAAA_AAAA, 4'b1111, 1'b0);
    rd_en_i   = 1'b1;
    rd_addr_i = 12'd7;
    wr_en_i   = 1'b1;
    wr_addr_i = 12'd7;
    wr_data_i = 32'h5555_5555;
    wr_be_i   = 4'b0011;
    step();
    idle_inputs();
    check("t4_coll_data",  rd_data_o, 32'hAAAA_5555);
    check("t4_coll_valid", {31'd0, rd_valid_o}, 32'd1);
    check("t4_coll_perr",  {31'd0, par_err_o},  32'd0);
    do_read("t4_rd7", 12'd7, 32'hAAAA_5555, 1'b0);

    // Different-address read and write in one cycle are independent
    rd_en_i   = 1'b1;
    rd_addr_i = 12'd5;
    wr_en_i   = 1'b1;
    wr_addr_i = 12'd8;
    wr_data_i = 32'hCAFE_F00D;
    wr_be_i   = 4'b1111;
    step();
    idle_inputs();
    check("indep_rd5", rd_data_o, 32'hDE22_BE44);
    do_read("indep_rd8", 12'd8, 32'hCAFE_F00D, 1'b0);

    // 5: reset 100 cycles into a sweep restarts it; busy writes are dropped
    do_write(12'd50, 32'h1234_5678, 4'b1111, 1'b0);
    do_read("t5_pre50", 12'd50, 32'h1234_5678, 1'b0);
    pulse_reset();
    for (int i = 0; i < 100; i++) step();
    check("t5_mid_busy", {31'd0, busy_o}, 32'd1);
    pulse_reset();
    count_busy(200, 12'd10, n_busy, saw_v);
    check("t5_sweep_cycles", n_busy, 32'd4096);
    check("t5_busy_no_valid", {31'd0, saw_v}, 32'd0);
    do_read("t5_rd50", 12'd50, 32'h0000_0000, 1'b0);
    do_read("t5_rd10", 12'd10, 32'h0000_0000, 1'b0);

    // 6: parity error injection on byte 0
`ifdef DFFRAM_PARITY_EN
    exp_par = 1'b1;
`else
    exp_par = 1'b0;
`endif
    do_write(12'd9, 32'h0000_00FF, 4'b0001, 1'b1);
    do_read("t6_inj", 12'd9, 32'h0000_00FF, exp_par);
    do_write(12'd9, 32'h0000_00FF, 4'b0001, 1'b0);
    do_read("t6_clean", 12'd9, 32'h0000_00FF, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
